branch_resolve_unit: RTL and testbench

- Other end of the predictor update interface: produces the update stream the branch predictor consumes.
- Holds every in-flight prediction from fetch in an in-order queue.
- Compares the oldest entry against the outcome resolved in EX and drives the one-cycle update pulse to the predictor.
- On a mispredict, raises a redirect and flushes all younger wrong-path predictions.

---
 rtl/branch_resolve_unit.sv | 137 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// In-order queue of fetch predictions, resolved against EX outcomes to drive predictor updates and redirects.
// Optional BRU_PERF_COUNTER_EN adds saturating update/mispredict counters.
module branch_resolve_unit #(
    parameter int QUEUE_DEPTH = 8,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           pred_valid_i,
    output logic                           pred_ready_o,
    input  logic [ADDR_WIDTH-1:0]          pred_pc_i,
    input  logic                           pred_taken_i,
    input  logic [ADDR_WIDTH-1:0]          pred_target_i,
    input  logic                           resolve_valid_i,
    input  logic                           resolve_taken_i,
    input  logic [ADDR_WIDTH-1:0]          resolve_target_i,
    output logic                           branch_valid_o,
    output logic                           branch_taken_o,
    output logic [ADDR_WIDTH-1:0]          branch_pc_o,
    output logic [ADDR_WIDTH-1:0]          branch_target_address_o,
    output logic                           mispredict_o,
    output logic [ADDR_WIDTH-1:0]          redirect_pc_o,
    output logic                           orphan_o,
`ifdef BRU_PERF_COUNTER_EN
    output logic [31:0]                    perf_branch_cnt_o,
    output logic [31:0]                    perf_mispredict_cnt_o,
`endif
    output logic [$clog2(QUEUE_DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {RUN, RECOVER} state_t;

    state_t                 state_reg;
    logic [PTR_W-1:0]       head_reg, tail_reg;
    logic [CNT_W-1:0]       count_reg;
    logic [ADDR_WIDTH-1:0]  pc_mem  [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  tgt_mem [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] taken_mem;

    logic                   push, pop, push_ok, wrong;
    logic [ADDR_WIDTH-1:0]  head_pc, head_tgt, next_pc;
    logic                   head_taken;

    assign pred_ready_o = (state_reg == RUN) && (count_reg < CNT_W'(QUEUE_DEPTH));
    assign count_o      = count_reg;

    assign head_pc    = pc_mem[head_reg];
    assign head_tgt   = tgt_mem[head_reg];
    assign head_taken = taken_mem[head_reg];

    assign push  = pred_valid_i && pred_ready_o;
    // RECOVER always has an empty queue, so its resolves fall through to orphan
    assign pop   = resolve_valid_i && (count_reg != '0) && (state_reg == RUN);
    assign wrong = (head_taken != resolve_taken_i) ||
                   (head_taken && resolve_taken_i && (head_tgt != resolve_target_i));
    assign next_pc = resolve_taken_i ? resolve_target_i : head_pc + ADDR_WIDTH'(4);
    // A mispredicting pop discards the whole wrong path, including this cycle's push
    assign push_ok = rst && !flush_i && push && !(pop && wrong);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[tail_reg]    <= pred_pc_i;
            tgt_mem[tail_reg]   <= pred_target_i;
            taken_mem[tail_reg] <= pred_taken_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg               <= RUN;
            head_reg                <= '0;
            tail_reg                <= '0;
            count_reg               <= '0;
            branch_valid_o          <= 1'b0;
            branch_taken_o          <= 1'b0;
            branch_pc_o             <= '0;
            branch_target_address_o <= '0;
            mispredict_o            <= 1'b0;
            redirect_pc_o           <= '0;
            orphan_o                <= 1'b0;
        end else begin
            branch_valid_o <= 1'b0;
            mispredict_o   <= 1'b0;
            orphan_o       <= 1'b0;
            if (flush_i) begin
                state_reg <= RUN;
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                orphan_o  <= resolve_valid_i && !pop;
                state_reg <= RUN;
                if (pop) begin
                    branch_valid_o          <= 1'b1;
                    branch_taken_o          <= resolve_taken_i;
                    branch_pc_o             <= head_pc;
                    branch_target_address_o <= next_pc;
                end
                if (pop && wrong) begin
                    mispredict_o  <= 1'b1;
                    redirect_pc_o <= next_pc;
                    state_reg     <= RECOVER;
                    head_reg      <= '0;
                    tail_reg      <= '0;
                    count_reg     <= '0;
                end else begin
                    if (pop)
                        head_reg <= head_reg + 1'b1;
                    if (push_ok)
                        tail_reg <= tail_reg + 1'b1;
                    if (push_ok && !pop)
                        count_reg <= count_reg + 1'b1;
                    else if (!push_ok && pop)
                        count_reg <= count_reg - 1'b1;
                end
            end
        end
    end

`ifdef BRU_PERF_COUNTER_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_branch_cnt_o     <= '0;
            perf_mispredict_cnt_o <= '0;
        end else begin
            if (branch_valid_o && (perf_branch_cnt_o != 32'hFFFF_FFFF))
                perf_branch_cnt_o <= perf_branch_cnt_o + 32'd1;
            if (mispredict_o && (perf_mispredict_cnt_o != 32'hFFFF_FFFF))
                perf_mispredict_cnt_o <= perf_mispredict_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: queue-based reference model checked every cycle plus directed literal checks.
// Build with BRU_PERF_COUNTER_EN to also check the performance counters.
module tb_branch_resolve_unit;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        pred_valid_i = 1'b0;
    logic        pred_ready_o;
    logic [31:0] pred_pc_i = '0;
    logic        pred_taken_i = 1'b0;
    logic [31:0] pred_target_i = '0;
    logic        resolve_valid_i = 1'b0;
    logic        resolve_taken_i = 1'b0;
    logic [31:0] resolve_target_i = '0;
    logic        branch_valid_o, branch_taken_o, mispredict_o, orphan_o;
    logic [31:0] branch_pc_o, branch_target_address_o, redirect_pc_o;
    logic [3:0]  count_o;
`ifdef BRU_PERF_COUNTER_EN
    logic [31:0] perf_branch_cnt_o, perf_mispredict_cnt_o;
`endif

    branch_resolve_unit #(.QUEUE_DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o),
        .pred_pc_i(pred_pc_i), .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
        .resolve_valid_i(resolve_valid_i), .resolve_taken_i(resolve_taken_i),
        .resolve_target_i(resolve_target_i),
        .branch_valid_o(branch_valid_o), .branch_taken_o(branch_taken_o),
        .branch_pc_o(branch_pc_o), .branch_target_address_o(branch_target_address_o),
        .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o), .orphan_o(orphan_o),
`ifdef BRU_PERF_COUNTER_EN
        .perf_branch_cnt_o(perf_branch_cnt_o), .perf_mispredict_cnt_o(perf_mispredict_cnt_o),
`endif
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue of outstanding predictions
    typedef struct { logic [31:0] pc; logic taken; logic [31:0] tgt; } ent_t;
    ent_t        mq[$];
    bit          m_recover = 0;
    logic        e_bv = 0, e_bt = 0, e_mp = 0, e_orph = 0;
    logic [31:0] e_bpc = 0, e_btgt = 0, e_rpc = 0;
    longint      e_pbc = 0, e_pmc = 0;

    always @(posedge clk) begin
        bit   ready, recover_nx, wrong;
        ent_t e;
        if (e_bv  && e_pbc < 64'hFFFF_FFFF) e_pbc++;
        if (e_mp  && e_pmc < 64'hFFFF_FFFF) e_pmc++;
        e_bv = 0; e_mp = 0; e_orph = 0; wrong = 0;
        if (!rst) begin
            mq.delete(); m_recover = 0;
            e_bt = 0; e_bpc = 0; e_btgt = 0; e_rpc = 0; e_pbc = 0; e_pmc = 0;
        end else if (flush_i) begin
            mq.delete(); m_recover = 0;
        end else begin
            ready = !m_recover && (mq.size() < DEPTH);
            recover_nx = 0;
            if (resolve_valid_i) begin
                if (!m_recover && mq.size() > 0) begin
                    e = mq.pop_front();
                    e_bv = 1; e_bt = resolve_taken_i; e_bpc = e.pc;
                    e_btgt = resolve_taken_i ? resolve_target_i : e.pc + 32'd4;
                    wrong = (e.taken != resolve_taken_i) || (e.taken && e.tgt != resolve_target_i);
                    if (wrong) begin
                        e_mp = 1; e_rpc = e_btgt; mq.delete(); recover_nx = 1;
                    end
                end else
                    e_orph = 1;
            end
            if (pred_valid_i && ready && !wrong)
                mq.push_back('{pred_pc_i, pred_taken_i, pred_target_i});
            m_recover = recover_nx;
        end
    end

    bit check_en = 0;
    always @(negedge clk) begin
        if (check_en) begin
            chk("ready", {31'd0, pred_ready_o}, {31'd0, !m_recover && mq.size() < DEPTH});
            chk("count", {28'd0, count_o}, mq.size());
            chk("branch_valid", {31'd0, branch_valid_o}, {31'd0, e_bv});
            chk("mispredict", {31'd0, mispredict_o}, {31'd0, e_mp});
            chk("orphan", {31'd0, orphan_o}, {31'd0, e_orph});
            if (e_bv) begin
                chk("branch_taken", {31'd0, branch_taken_o}, {31'd0, e_bt});
                chk("branch_pc", branch_pc_o, e_bpc);
                chk("branch_target", branch_target_address_o, e_btgt);
            end
            if (e_mp) chk("redirect_pc", redirect_pc_o, e_rpc);
`ifdef BRU_PERF_COUNTER_EN
            chk("perf_branch", perf_branch_cnt_o, e_pbc[31:0]);
            chk("perf_mispredict", perf_mispredict_cnt_o, e_pmc[31:0]);
`endif
        end
    end

    // One clock of stimulus; outputs are settled 1 time unit after the edge
    task automatic cyc(input logic pv, input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                       input logic rv, input logic rt, input logic [31:0] rtgt, input logic fl);
        pred_valid_i = pv; pred_pc_i = pc; pred_taken_i = pt; pred_target_i = ptgt;
        resolve_valid_i = rv; resolve_taken_i = rt; resolve_target_i = rtgt; flush_i = fl;
        @(posedge clk); #1;
        pred_valid_i = 0; resolve_valid_i = 0; flush_i = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
        cyc(1, pc, pt, ptgt, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic rt, input logic [31:0] rtgt);
        cyc(0, 0, 0, 0, 1, rt, rtgt, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 0;
        @(posedge clk); #1;
        check_en = 1;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, pred_ready_o}, 32'd1);
        chk("rst_count", {28'd0, count_o}, 32'd0);
        chk("rst_bv", {31'd0, branch_valid_o}, 32'd0);
        rst = 1;
        idle();

        // Correctly predicted taken branch
        push(32'h1c000100, 1, 32'h1c000200);
        resolve(1, 32'h1c000200);
        $display("T1 correct taken: bv=%0b pc=%h tgt=%h mp=%0b", branch_valid_o, branch_pc_o, branch_target_address_o, mispredict_o);
        chk("t1_bv", {31'd0, branch_valid_o}, 32'd1);
        chk("t1_bt", {31'd0, branch_taken_o}, 32'd1);
        chk("t1_pc", branch_pc_o, 32'h1c000100);
        chk("t1_tgt", branch_target_address_o, 32'h1c000200);
        chk("t1_mp", {31'd0, mispredict_o}, 32'd0);

        // Direction mispredict flushes three younger entries
        push(32'h1c000100, 1, 32'h1c000200);
        for (int i = 1; i < 4; i++) push(32'h1c000100 + 32'(i * 16), 0, 0);
        chk("t2_count4", {28'd0, count_o}, 32'd4);
        resolve(0, 0);
        $display("T2 dir mispredict: mp=%0b redirect=%h count=%0d ready=%0b", mispredict_o, redirect_pc_o, count_o, pred_ready_o);
        chk("t2_bv", {31'd0, branch_valid_o}, 32'd1);
        chk("t2_mp", {31'd0, mispredict_o}, 32'd1);
        chk("t2_redirect", redirect_pc_o, 32'h1c000104);
        chk("t2_count0", {28'd0, count_o}, 32'd0);
        chk("t2_ready0", {31'd0, pred_ready_o}, 32'd0);
        idle();
        chk("t2_ready1", {31'd0, pred_ready_o}, 32'd1);

        // Fill, push refused while full, refill across the wrap, drain in order
        for (int i = 0; i < 8; i++) push(32'h1c001000 + 32'(i * 4), 0, 0);
        $display("T3 full: count=%0d ready=%0b", count_o, pred_ready_o);
        chk("t3_ready_full", {31'd0, pred_ready_o}, 32'd0);
        chk("t3_count8", {28'd0, count_o}, 32'd8);
        cyc(1, 32'hdead0000, 0, 0, 1, 0, 0, 0);
        chk("t3_count7", {28'd0, count_o}, 32'd7);
        chk("t3_ready1", {31'd0, pred_ready_o}, 32'd1);
        chk("t3_pc0", branch_pc_o, 32'h1c001000);
        push(32'h1c002000, 0, 0);
        chk("t3_refill", {28'd0, count_o}, 32'd8);
        for (int i = 1; i < 9; i++) begin
            resolve(0, 0);
            $display("T3 drain %0d: pc=%h tgt=%h", i, branch_pc_o, branch_target_address_o);
            chk("t3_order", branch_pc_o, (i < 8) ? 32'h1c001000 + 32'(i * 4) : 32'h1c002000);
        end

        // Target mispredict, then a resolve during recovery is an orphan
        push(32'h1c000500, 1, 32'h1c000300);
        resolve(1, 32'h1c000400);
        $display("T4 tgt mispredict: mp=%0b redirect=%h", mispredict_o, redirect_pc_o);
        chk("t4_mp", {31'd0, mispredict_o}, 32'd1);
        chk("t4_redirect", redirect_pc_o, 32'h1c000400);
        resolve(1, 0);
        chk("t4_recover_orphan", {31'd0, orphan_o}, 32'd1);

        // pc+4 wraps at the top of the address space
        push(32'hfffffffc, 1, 32'h00001000);
        resolve(0, 0);
        $display("T5 wrap: redirect=%h", redirect_pc_o);
        chk("t5_wrap", redirect_pc_o, 32'h00000000);

        // Empty resolve, then flush concurrent with a resolve
        idle();
        resolve(1, 32'h1c000800);
        $display("T6 empty resolve: orphan=%0b bv=%0b", orphan_o, branch_valid_o);
        chk("t6_orphan", {31'd0, orphan_o}, 32'd1);
        chk("t6_bv", {31'd0, branch_valid_o}, 32'd0);
        for (int i = 0; i < 3; i++) push(32'h1c003000 + 32'(i * 4), 1, 32'h1c004000);
        cyc(1, 32'h1c005000, 0, 0, 1, 0, 0, 1);
        $display("T6 flush: bv=%0b mp=%0b orphan=%0b count=%0d ready=%0b", branch_valid_o, mispredict_o, orphan_o, count_o, pred_ready_o);
        chk("t6_fl_bv", {31'd0, branch_valid_o}, 32'd0);
        chk("t6_fl_mp", {31'd0, mispredict_o}, 32'd0);
        chk("t6_fl_count", {28'd0, count_o}, 32'd0);
        chk("t6_fl_ready", {31'd0, pred_ready_o}, 32'd1);

        // Mispredict immediately followed by flush aborts recovery
        push(32'h1c006000, 0, 0);
        resolve(1, 32'h1c007000);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t7_ready", {31'd0, pred_ready_o}, 32'd1);

        // Reset mid-operation
        push(32'h1c008000, 0, 0);
        push(32'h1c008004, 0, 0);
        rst = 0;
        resolve(1, 32'h1c009000);
        rst = 1;
        idle();
        $display("T8 mid reset: count=%0d bv=%0b", count_o, branch_valid_o);
        chk("t8_count", {28'd0, count_o}, 32'd0);
        chk("t8_bv", {31'd0, branch_valid_o}, 32'd0);
        resolve(0, 0);
        chk("t8_orphan", {31'd0, orphan_o}, 32'd1);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
